// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single write port of the async FIFO write side between
//   NUM_REQ requesters in the write clock domain. Ownership is handed out
//   round-robin, each grant is limited to BURST_LEN words, and wfull is
//   honoured on every cycle. Every release passes through one IDLE cycle
//   before the next grant.
//
// Parameters
//   NUM_REQ    number of requesters (2..8)
//   DATA_W     FIFO word width
//   BURST_LEN  maximum words per grant (1..15)
//   CNT_W      width of each statistics counter
//
// Ports
//   clk        write-domain clock
//   rst        synchronous active-low reset
//   req_valid  per-requester word available
//   req_data   packed data, requester i at [i*DATA_W +: DATA_W]
//   req_ready  per-requester word accepted this cycle
//   wfull      full flag from the FIFO write side
//   winc       write strobe to the FIFO write side
//   wdata      write data to the FIFO memory
//   grant      one-hot current owner, 0 when idle
//   busy       high while a requester owns the port
//   stat_cnt   per-requester accepted-word counts, CNT_W bits each
//
// Build option
//   ARB_STATS_EN  when defined, stat_cnt holds saturating per-requester
//                 transfer counts; otherwise stat_cnt is tied to 0 and no
//                 counter flops exist.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wfull,
  output logic                      winc,
  output logic [DATA_W-1:0]         wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic [NUM_REQ*CNT_W-1:0]  stat_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BC_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [BC_W-1:0]    burst_q, burst_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;

  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   idx;
  logic               owner_valid;
  logic               active;

  // Round-robin search starting one past the last owner, with wrap.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Outputs are gated by rst so a reset mid-burst stops the write in the
  // same cycle rather than one edge later.
  always_comb begin
    active      = rst && (state_q == GRANT);
    owner_valid = |(req_valid & grant_q);
    winc        = active && owner_valid && !wfull;
    req_ready   = (active && !wfull) ? grant_q : '0;
    grant       = rst ? grant_q : '0;
    busy        = active;
    wdata       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) wdata = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          last_d  = pick;
          burst_d = '0;
          grant_d = NUM_REQ'(1) << pick;
        end
      end
      GRANT: begin
        // A transfer beats an owner drop; an owner drop beats a wfull stall.
        if (winc) begin
          if (burst_q == BC_LAST) begin
            state_d = IDLE;
            grant_d = '0;
            burst_d = '0;
          end else begin
            burst_d = burst_q + 1'b1;
          end
        end else if (!owner_valid) begin
          state_d = IDLE;
          grant_d = '0;
          burst_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      burst_q <= '0;
      last_q  <= IDX_LAST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [NUM_REQ*CNT_W-1:0] stat_q;

  // Per-requester transfer counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (winc && grant_q[i] && !(&stat_q[i*CNT_W +: CNT_W]))
          stat_q[i*CNT_W +: CNT_W] <= stat_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  assign stat_cnt = stat_q;
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter. Requester models hold a queue of
//   words each; the same words go into a per-requester expected queue that
//   is popped whenever the arbiter writes on behalf of that requester.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wfull;
  logic                      winc;
  logic [DATA_W-1:0]         wdata;
  logic [NUM_REQ-1:0]        grant;
  logic                      busy;
  logic [NUM_REQ*CNT_W-1:0]  stat_cnt;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .BURST_LEN(BURST_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .grant    (grant),
    .busy     (busy),
    .stat_cnt (stat_cnt)
  );

  logic [DATA_W-1:0] src   [NUM_REQ][$];
  logic [DATA_W-1:0] exp_q [NUM_REQ][$];
  int grant_log[$];
  int burst_log[$];

  int vectors     = 0;
  int miscompares = 0;
  int seq         = 0;
  int cur_words   = 0;
  logic prev_busy = 1'b0;

  logic               s_winc, s_busy;
  logic [NUM_REQ-1:0] s_grant, s_rdy;
  logic [DATA_W-1:0]  s_wdata;
  logic [31:0]        tr_winc, tr_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int idx_of(input logic [NUM_REQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic load(input int r, input int n);
    logic [DATA_W-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = DATA_W'((r << 6) | (seq & 63));
      seq++;
      src[r].push_back(d);
      exp_q[r].push_back(d);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_REQ; i++) begin
      src[i].delete();
      exp_q[i].delete();
    end
    grant_log.delete();
    burst_log.delete();
    tr_winc   = '0;
    tr_busy   = '0;
    cur_words = 0;
    prev_busy = 1'b0;
  endtask

  // One clock: drive requester inputs, sample at the falling edge, score
  // any write, then advance past the rising edge.
  task automatic step();
    int g;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = (src[i].size() > 0);
      req_data[i*DATA_W +: DATA_W] = (src[i].size() > 0) ? src[i][0] : '0;
    end
    @(negedge clk);
    s_winc  = winc;
    s_busy  = busy;
    s_grant = grant;
    s_rdy   = req_ready;
    s_wdata = wdata;
    tr_winc = {tr_winc[30:0], s_winc};
    tr_busy = {tr_busy[30:0], s_busy};
    if (s_busy && !prev_busy) begin
      grant_log.push_back(idx_of(s_grant));
      cur_words = 0;
    end
    if (s_winc) begin
      cur_words++;
      g = idx_of(s_grant);
      chk("grant_onehot", 32'($onehot(s_grant)), 1);
      chk("sb_nonempty", 32'(g >= 0 && exp_q[g].size() > 0), 1);
      if (g >= 0 && exp_q[g].size() > 0) chk("wdata", s_wdata, exp_q[g].pop_front());
    end
    if (!s_busy && prev_busy) burst_log.push_back(cur_words);
    prev_busy = s_busy;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && s_rdy[i]) void'(src[i].pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_all();
    step();
    chk("rst_winc",  32'(s_winc),  0);
    chk("rst_busy",  32'(s_busy),  0);
    chk("rst_grant", 32'(s_grant), 0);
    chk("rst_ready", 32'(s_rdy),   0);
    step();
    rst = 1'b1;
    clear_all();
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    wfull     = 1'b0;

    // Single requester, 6 words: burst of 4, bubble, regrant, 2 more words.
    do_reset();
    step();
    chk("idle_busy", 32'(s_busy), 0);
    clear_all();
    load(0, 6);
    for (int k = 0; k < 10; k++) step();
    chk("t1_winc_trace", tr_winc[9:0], 32'b0111101100);
    chk("t1_busy_trace", tr_busy[9:0], 32'b0111101110);
    chk("t1_drained", exp_q[0].size(), 0);
    chk("t1_bursts", burst_log.size(), 2);
    if (burst_log.size() == 2) begin
      chk("t1_burst0", burst_log[0], 4);
      chk("t1_burst1", burst_log[1], 2);
    end

    // All four requesters busy from reset: order 0,1,2,3,0, 4 words each.
    do_reset();
    for (int r = 0; r < NUM_REQ; r++) load(r, 8);
    for (int k = 0; k < 26; k++) step();
    chk("t2_busy_trace", tr_busy[25:0], 32'b01111011110111101111011110);
    chk("t2_grants", 32'(grant_log.size() >= 5), 1);
    if (grant_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("t2_grant_order", grant_log[k], k % NUM_REQ);
    end
    if (burst_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("t2_burst_len", burst_log[k], BURST_LEN);
    end
`ifndef ARB_STATS_EN
    chk("t2_stat_tied", stat_cnt, 0);
`endif

    // wfull high for 3 cycles after the 2nd word of a burst.
    do_reset();
    load(0, 4);
    step();
    step();
    step();
    wfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_stall_winc",  32'(s_winc),  0);
      chk("t3_stall_ready", 32'(s_rdy),   0);
      chk("t3_stall_grant", 32'(s_grant), 32'b0001);
    end
    wfull = 1'b0;
    step();
    step();
    step();
    chk("t3_winc_trace", tr_winc[8:0], 32'b011000110);
    chk("t3_drained", exp_q[0].size(), 0);
    chk("t3_bursts", burst_log.size(), 1);
    if (burst_log.size() == 1) chk("t3_burst_len", burst_log[0], 4);

    // Owner drops valid after one word while requester 2 waits.
    do_reset();
    load(0, 1);
    load(2, 2);
    for (int k = 0; k < 7; k++) step();
    chk("t4_winc_trace", tr_winc[6:0], 32'b0100110);
    chk("t4_busy_trace", tr_busy[6:0], 32'b0110111);
    chk("t4_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t4_grant0", grant_log[0], 0);
      chk("t4_grant1", grant_log[1], 2);
    end
    chk("t4_drained", exp_q[2].size(), 0);

    // Reset mid-burst, then all four valid: requester 0 wins first.
    do_reset();
    load(0, 4);
    step();
    step();
    step();
    rst = 1'b0;
    step();
    chk("t5_grant", 32'(s_grant), 0);
    chk("t5_winc",  32'(s_winc),  0);
    chk("t5_busy",  32'(s_busy),  0);
    chk("t5_ready", 32'(s_rdy),   0);
    clear_all();
    rst = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) load(r, 2);
    step();
    step();
    chk("t5_first", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 0);

`ifdef ARB_STATS_EN
    // Requester 1 sends 20 words into a 4-bit counter.
    do_reset();
    load(1, 20);
    for (int k = 0; k < 30; k++) step();
    chk("t6_stat1", stat_cnt[1*CNT_W +: CNT_W], 15);
    chk("t6_stat0", stat_cnt[0*CNT_W +: CNT_W], 0);
    chk("t6_stat2", stat_cnt[2*CNT_W +: CNT_W], 0);
    chk("t6_stat3", stat_cnt[3*CNT_W +: CNT_W], 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
